mprc_meta_array: RTL and testbench
==================================

// Module: mprc_meta_array
// PURPOSE
//  4-way L1 D-cache metadata (tag + coherence) store; responder for the s1 meta read and the meta write/update requests.
//  Returns meta_io_resp_{0..3}_{coh,tag} one cycle after an accepted read; these outputs feed stage-2 hit/replacement logic.
//  After reset, walks every set and marks all ways `clientInvalid`.
// PARAMETERS
//  NSETS   64   number of sets (power of 2)
//  IDX_W   6    set index width, log2(NSETS)
//  TAG_W   20   tag width
//  COH_W   2    coherence state width (encodings from common.vh)
// PORTS
//  clk              in   1      clock
//  reset_n          in   1      asynchronous, active-low reset
//  read_valid       in   1      read request
//  read_ready       out  1      read accepted when read_valid & read_ready
//  read_idx         in   IDX_W  set to read
//  write_valid      in   1      write request
//  write_ready      out  1      write accepted when write_valid & write_ready
//  write_idx        in   IDX_W  set to write
//  write_way_en     in   4      one-hot or multi-hot way select
//  write_tag        in   TAG_W  tag written to the selected ways
//  write_coh        in   COH_W  coherence state written to the selected ways
//  resp_valid       out  1      meta_io_resp_* valid (pulses 1 cycle after read accept)
//  meta_io_resp_N_coh out COH_W  way N coherence state, N=0..3
//  meta_io_resp_N_tag out TAG_W  way N tag, N=0..3
//  init_done        out  1      reset walk complete
// BEHAVIOUR
//  Reset (async, reset_n=0): state=INIT, init_idx=0, init_done=0, resp_valid=0, all meta_io_resp_*=0, ready outputs=0.
//  INIT state: each cycle, write {tag=0, coh=`clientInvalid} to all 4 ways of init_idx; init_idx++.
//   After writing index NSETS-1: state=RUN, init_done=1. Total NSETS cycles. read_ready=write_ready=0 throughout INIT.
//  Reassertion of reset_n at any time (including mid-INIT): restart INIT from idx 0; pending response is dropped.
//  RUN state: single-ported storage. write_ready=1; read_ready = ~write_valid (write wins).
//   Write: on accept, ways with write_way_en[N]=1 get {write_tag, write_coh} at the next edge; other ways unchanged.
//   write_way_en=0 is a legal no-op.
//   Read: on accept in cycle t, resp_valid=1 in cycle t+1, with meta_io_resp_N = contents of read_idx at edge t (pre-write).
//   meta_io_resp_* hold their last value while resp_valid=0; resp_valid is 0 in any cycle without an accept in the preceding cycle.
//   Back-to-back reads: one per cycle, full throughput.
//  Arithmetic: init_idx is IDX_W+1 bits, so the terminal compare (== NSETS-1) does not wrap silently.
//   read_idx and write_idx are used unmodified, so every value is in range.
// CONFIGURATION
//  META_WRITE_BYPASS_EN defined: dual-ported storage. read_ready=1 in RUN, independent of write_valid.
//   A read and a write accepted in the same cycle with read_idx==write_idx: response way N returns the write data when write_way_en[N]=1, stored data otherwise.
//  Undefined: single port as above; a same-cycle collision is impossible because read_ready=0.
// STRUCTURE
//  common.vh: coherence encodings (`clientInvalid etc., already present). Add new `META_TAG_W, `META_COH_W, `META_IDX_W defines.
//  Sub-module mprc_meta_way: one way's NSETS x (TAG_W+COH_W) flop array with write enable and a registered read; instantiate 4x.
//  Top level holds the INIT/RUN FSM, init counter, ready/valid logic, bypass muxing and resp_valid flop.
// TESTING
//  1 Release reset; count cycles -> init_done rises exactly NSETS(64) cycles later, ready outputs 0 until then.
//    Then read every idx -> all coh==`clientInvalid, tag==0.
//  2 Write idx 5, way_en=4'b0100, tag=20'hABCDE, coh=`clientExclusiveDirty; then read idx 5 ->
//    next cycle resp_valid=1, resp_2={ExclusiveDirty,ABCDE}, resp_0/1/3 still Invalid/0.
//  3 read_valid & write_valid same cycle (bypass off) -> read_ready=0, write lands.
//    Read next cycle -> returns the new data.
//  4 Reads idx 1,2,3 on consecutive cycles after distinct writes -> resp_valid high 3 consecutive cycles with matching data.
//    Outputs hold after the last response.
//  5 Drop reset_n at INIT cycle 30, release -> init restarts; init_done after a further 64 cycles.
//    Data written before the reset reads back as Invalid.
//  6 (META_WRITE_BYPASS_EN) same-cycle read/write idx 9, way_en=4'b0011, tag=20'h12345 ->
//    read_ready=1; resp_0/1 = new data, resp_2/3 = old data.

Source files
------------

// File: rtl/mprc_meta_array_pkg.sv
// Shared geometry, coherence encodings and FSM state type for the L1 D-cache metadata array.
package mprc_meta_array_pkg;

    localparam int unsigned META_NSETS = 64;
    localparam int unsigned META_IDX_W = 6;
    localparam int unsigned META_TAG_W = 20;
    localparam int unsigned META_COH_W = 2;
    localparam int unsigned META_WAYS  = 4;

    localparam logic [META_COH_W-1:0] COH_CLIENT_INVALID         = 2'd0;
    localparam logic [META_COH_W-1:0] COH_CLIENT_SHARED          = 2'd1;
    localparam logic [META_COH_W-1:0] COH_CLIENT_EXCLUSIVE_CLEAN = 2'd2;
    localparam logic [META_COH_W-1:0] COH_CLIENT_EXCLUSIVE_DIRTY = 2'd3;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } meta_state_e;

endpackage

// File: rtl/mprc_meta_way.sv
// One way of the metadata store: NSETS x {tag, coh} flop array with one write port
// and a registered read whose value holds until the next read.
module mprc_meta_way
    import mprc_meta_array_pkg::*;
#(
    parameter int unsigned NSETS = META_NSETS,
    parameter int unsigned IDX_W = META_IDX_W,
    parameter int unsigned TAG_W = META_TAG_W,
    parameter int unsigned COH_W = META_COH_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [TAG_W-1:0] wtag_i,
    input  logic [COH_W-1:0] wcoh_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] ridx_i,
    input  logic             byp_i,
    output logic [TAG_W-1:0] rtag_o,
    output logic [COH_W-1:0] rcoh_o
);

    logic [TAG_W+COH_W-1:0] mem_q [NSETS];
    logic [TAG_W+COH_W-1:0] rd_q;

    // Storage array; contents are established by the reset walk, so no reset here.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[widx_i] <= {wtag_i, wcoh_i};
        end
    end

    // Read register samples pre-write contents, or the incoming write data on a bypass hit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q <= '0;
        end else if (re_i) begin
            rd_q <= byp_i ? {wtag_i, wcoh_i} : mem_q[ridx_i];
        end else begin
            rd_q <= rd_q;
        end
    end

    assign rtag_o = rd_q[TAG_W+COH_W-1:COH_W];
    assign rcoh_o = rd_q[COH_W-1:0];

endmodule

// File: rtl/mprc_meta_array.sv
// 4-way L1 D-cache metadata store with reset-time invalidation walk.
// Build option META_WRITE_BYPASS_EN: dual-ported, same-cycle read/write forwarding.
module mprc_meta_array
    import mprc_meta_array_pkg::*;
#(
    parameter int unsigned NSETS = META_NSETS,
    parameter int unsigned IDX_W = META_IDX_W,
    parameter int unsigned TAG_W = META_TAG_W,
    parameter int unsigned COH_W = META_COH_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             read_valid,
    output logic             read_ready,
    input  logic [IDX_W-1:0] read_idx,
    input  logic             write_valid,
    output logic             write_ready,
    input  logic [IDX_W-1:0] write_idx,
    input  logic [3:0]       write_way_en,
    input  logic [TAG_W-1:0] write_tag,
    input  logic [COH_W-1:0] write_coh,
    output logic             resp_valid,
    output logic [COH_W-1:0] meta_io_resp_0_coh,
    output logic [TAG_W-1:0] meta_io_resp_0_tag,
    output logic [COH_W-1:0] meta_io_resp_1_coh,
    output logic [TAG_W-1:0] meta_io_resp_1_tag,
    output logic [COH_W-1:0] meta_io_resp_2_coh,
    output logic [TAG_W-1:0] meta_io_resp_2_tag,
    output logic [COH_W-1:0] meta_io_resp_3_coh,
    output logic [TAG_W-1:0] meta_io_resp_3_tag,
    output logic             init_done
);

    localparam logic [IDX_W:0] INIT_LAST = (IDX_W+1)'(NSETS - 1);

    meta_state_e      state_q, state_d;
    logic [IDX_W:0]   init_idx_q, init_idx_d;
    logic             init_done_q, init_done_d;
    logic             resp_valid_q;

    logic             run_s;
    logic             rd_acc_s;
    logic             wr_acc_s;
    logic [3:0]       way_we_s;
    logic [3:0]       way_byp_s;
    logic [IDX_W-1:0] way_widx_s;
    logic [TAG_W-1:0] way_wtag_s;
    logic [COH_W-1:0] way_wcoh_s;
    logic [TAG_W-1:0] rd_tag_s [4];
    logic [COH_W-1:0] rd_coh_s [4];

    assign run_s       = (state_q == ST_RUN);
    assign write_ready = run_s;
    assign wr_acc_s    = write_valid & write_ready;
    assign rd_acc_s    = read_valid & read_ready;

`ifdef META_WRITE_BYPASS_EN
    assign read_ready = run_s;
    assign way_byp_s  = (rd_acc_s && wr_acc_s && (read_idx == write_idx)) ? write_way_en : 4'b0000;
`else
    // Single port: a pending write blocks the read, so no forwarding is ever needed.
    assign read_ready = run_s & ~write_valid;
    assign way_byp_s  = 4'b0000;
`endif

    // State, walk counter, init flag and response-valid registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_INIT;
            init_idx_q   <= '0;
            init_done_q  <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_idx_q   <= init_idx_d;
            init_done_q  <= init_done_d;
            resp_valid_q <= rd_acc_s;
        end
    end

    // INIT walks every set once, then the FSM parks in RUN.
    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_INIT: begin
                if (init_idx_q == INIT_LAST) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end else begin
                    init_idx_d  = init_idx_q + (IDX_W+1)'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d     = ST_INIT;
                init_idx_d  = '0;
                init_done_d = 1'b0;
            end
        endcase
    end

    // Write port source: the invalidation walk during INIT, the request port in RUN.
    always_comb begin
        if (state_q == ST_INIT) begin
            way_we_s   = 4'b1111;
            way_widx_s = init_idx_q[IDX_W-1:0];
            way_wtag_s = '0;
            way_wcoh_s = COH_CLIENT_INVALID;
        end else begin
            way_we_s   = wr_acc_s ? write_way_en : 4'b0000;
            way_widx_s = write_idx;
            way_wtag_s = write_tag;
            way_wcoh_s = write_coh;
        end
    end

    for (genvar w = 0; w < 4; w++) begin : g_way
        mprc_meta_way #(
            .NSETS (NSETS),
            .IDX_W (IDX_W),
            .TAG_W (TAG_W),
            .COH_W (COH_W)
        ) u_way (
            .clk     (clk),
            .reset_n (reset_n),
            .we_i    (way_we_s[w]),
            .widx_i  (way_widx_s),
            .wtag_i  (way_wtag_s),
            .wcoh_i  (way_wcoh_s),
            .re_i    (rd_acc_s),
            .ridx_i  (read_idx),
            .byp_i   (way_byp_s[w]),
            .rtag_o  (rd_tag_s[w]),
            .rcoh_o  (rd_coh_s[w])
        );
    end

    assign resp_valid         = resp_valid_q;
    assign init_done          = init_done_q;
    assign meta_io_resp_0_tag = rd_tag_s[0];
    assign meta_io_resp_0_coh = rd_coh_s[0];
    assign meta_io_resp_1_tag = rd_tag_s[1];
    assign meta_io_resp_1_coh = rd_coh_s[1];
    assign meta_io_resp_2_tag = rd_tag_s[2];
    assign meta_io_resp_2_coh = rd_coh_s[2];
    assign meta_io_resp_3_tag = rd_tag_s[3];
    assign meta_io_resp_3_coh = rd_coh_s[3];

endmodule

// File: tb/tb_mprc_meta_array.sv
// Randomized self-checking bench for mprc_meta_array against an array-based reference model.
`timescale 1ns/1ps
module tb_mprc_meta_array;
    import mprc_meta_array_pkg::*;

`ifdef META_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        read_valid, read_ready, write_valid, write_ready;
    logic [5:0]  read_idx, write_idx;
    logic [3:0]  write_way_en;
    logic [19:0] write_tag;
    logic [1:0]  write_coh;
    logic        resp_valid, init_done;
    logic [1:0]  c0, c1, c2, c3;
    logic [19:0] t0, t1, t2, t3;

    int n_checks = 0;
    int n_errors = 0;

    logic [19:0] m_tag [4][64];
    logic [1:0]  m_coh [4][64];
    logic [19:0] e_tag [4];
    logic [1:0]  e_coh [4];

    always #5 clk = ~clk;

    mprc_meta_array dut (
        .clk (clk), .reset_n (reset_n),
        .read_valid (read_valid), .read_ready (read_ready), .read_idx (read_idx),
        .write_valid (write_valid), .write_ready (write_ready), .write_idx (write_idx),
        .write_way_en (write_way_en), .write_tag (write_tag), .write_coh (write_coh),
        .resp_valid (resp_valid),
        .meta_io_resp_0_coh (c0), .meta_io_resp_0_tag (t0),
        .meta_io_resp_1_coh (c1), .meta_io_resp_1_tag (t1),
        .meta_io_resp_2_coh (c2), .meta_io_resp_2_tag (t2),
        .meta_io_resp_3_coh (c3), .meta_io_resp_3_tag (t3),
        .init_done (init_done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_resp(input string tag);
        check_val({tag, "_t0"}, 32'(t0), 32'(e_tag[0]));
        check_val({tag, "_t1"}, 32'(t1), 32'(e_tag[1]));
        check_val({tag, "_t2"}, 32'(t2), 32'(e_tag[2]));
        check_val({tag, "_t3"}, 32'(t3), 32'(e_tag[3]));
        check_val({tag, "_c0"}, 32'(c0), 32'(e_coh[0]));
        check_val({tag, "_c1"}, 32'(c1), 32'(e_coh[1]));
        check_val({tag, "_c2"}, 32'(c2), 32'(e_coh[2]));
        check_val({tag, "_c3"}, 32'(c3), 32'(e_coh[3]));
    endtask

    task automatic idle_inputs();
        read_valid = 1'b0; read_idx = 6'd0;
        write_valid = 1'b0; write_idx = 6'd0; write_way_en = 4'b0000;
        write_tag = 20'd0; write_coh = 2'd0;
    endtask

    // Assert reset, check the reset state, clear the model, release on a negedge.
    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        #2;
        check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_val("rst_init_done", 32'(init_done), 32'd0);
        check_val("rst_read_ready", 32'(read_ready), 32'd0);
        check_val("rst_write_ready", 32'(write_ready), 32'd0);
        for (int w = 0; w < 4; w++) begin
            e_tag[w] = 20'd0;
            e_coh[w] = COH_CLIENT_INVALID;
            for (int s = 0; s < 64; s++) begin
                m_tag[w][s] = 20'd0;
                m_coh[w][s] = COH_CLIENT_INVALID;
            end
        end
        check_resp("rst");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Count clock edges from reset release until init_done, ready must stay low meanwhile.
    task automatic wait_init(input string tag);
        int cnt;
        cnt = 0;
        while (cnt < 200) begin
            @(posedge clk);
            cnt++;
            #1;
            if (init_done) break;
            check_val("init_read_ready", 32'(read_ready), 32'd0);
            check_val("init_write_ready", 32'(write_ready), 32'd0);
        end
        check_val(tag, 32'(cnt), 32'd64);
        @(negedge clk);
    endtask

    // One RUN-state cycle: drive, check ready, predict response, update model, check outputs.
    task automatic do_cycle(input logic rv, input logic [5:0] ri, input logic wv,
                            input logic [5:0] wi, input logic [3:0] wen,
                            input logic [19:0] wt, input logic [1:0] wc);
        logic exp_rr, racc;
        read_valid = rv; read_idx = ri;
        write_valid = wv; write_idx = wi; write_way_en = wen;
        write_tag = wt; write_coh = wc;
        exp_rr = BYP ? 1'b1 : ~wv;
        #1;
        check_val("read_ready", 32'(read_ready), 32'(exp_rr));
        check_val("write_ready", 32'(write_ready), 32'd1);
        racc = rv & exp_rr;
        if (racc) begin
            for (int w = 0; w < 4; w++) begin
                if (BYP && wv && wen[w] && (ri == wi)) begin
                    e_tag[w] = wt; e_coh[w] = wc;
                end else begin
                    e_tag[w] = m_tag[w][ri]; e_coh[w] = m_coh[w][ri];
                end
            end
        end
        @(posedge clk);
        if (wv) begin
            for (int w = 0; w < 4; w++) begin
                if (wen[w]) begin
                    m_tag[w][wi] = wt; m_coh[w][wi] = wc;
                end
            end
        end
        @(negedge clk);
        check_val("resp_valid", 32'(resp_valid), 32'(racc));
        check_resp("resp");
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b1;
        #2;
        do_reset();
        wait_init("init_cycles");

        for (int i = 0; i < 64; i++) do_cycle(1'b1, 6'(i), 1'b0, 6'd0, 4'b0000, 20'd0, 2'd0);

        do_cycle(1'b0, 6'd0, 1'b1, 6'd5, 4'b0100, 20'hABCDE, COH_CLIENT_EXCLUSIVE_DIRTY);
        do_cycle(1'b1, 6'd5, 1'b0, 6'd0, 4'b0000, 20'd0, 2'd0);

        do_cycle(1'b1, 6'd7, 1'b1, 6'd7, 4'b1000, 20'h55AA5, COH_CLIENT_SHARED);
        do_cycle(1'b1, 6'd7, 1'b0, 6'd0, 4'b0000, 20'd0, 2'd0);

        do_cycle(1'b0, 6'd0, 1'b1, 6'd1, 4'b0001, 20'h11111, COH_CLIENT_SHARED);
        do_cycle(1'b0, 6'd0, 1'b1, 6'd2, 4'b0010, 20'h22222, COH_CLIENT_EXCLUSIVE_CLEAN);
        do_cycle(1'b0, 6'd0, 1'b1, 6'd3, 4'b1111, 20'h33333, COH_CLIENT_EXCLUSIVE_DIRTY);
        for (int i = 1; i < 4; i++) do_cycle(1'b1, 6'(i), 1'b0, 6'd0, 4'b0000, 20'd0, 2'd0);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 6'd0, 1'b0, 6'd0, 4'b0000, 20'd0, 2'd0);

        do_cycle(1'b0, 6'd0, 1'b1, 6'd9, 4'b1111, 20'h0F0F0, COH_CLIENT_SHARED);
        do_cycle(1'b1, 6'd9, 1'b1, 6'd9, 4'b0011, 20'h12345, COH_CLIENT_EXCLUSIVE_DIRTY);
        do_cycle(1'b1, 6'd9, 1'b1, 6'd8, 4'b0000, 20'hFFFFF, COH_CLIENT_SHARED);

        for (int i = 0; i < 400; i++) begin
            do_cycle(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                     4'($urandom), 20'($urandom), 2'($urandom));
        end

        do_cycle(1'b0, 6'd0, 1'b1, 6'd5, 4'b1111, 20'hBEEF1, COH_CLIENT_EXCLUSIVE_CLEAN);
        do_reset();
        for (int i = 0; i < 30; i++) @(posedge clk);
        #1;
        check_val("mid_init_done", 32'(init_done), 32'd0);
        do_reset();
        wait_init("reinit_cycles");
        do_cycle(1'b1, 6'd5, 1'b0, 6'd0, 4'b0000, 20'd0, 2'd0);
        do_cycle(1'b1, 6'd9, 1'b0, 6'd0, 4'b0000, 20'd0, 2'd0);
        do_cycle(1'b1, 6'd63, 1'b0, 6'd0, 4'b0000, 20'd0, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
